lfp_mac_acc_q6_11: RTL and testbench

Sequential Q6.11 multiply-accumulate engine for the LSTM datapath. It consumes a stream of operand pairs over a valid/ready handshake and accumulates LEN products in a wide register. It then emits one rounded, saturated Q6.11 dot-product result over a second valid/ready handshake. It is the accumulating consumer for the combinational Q6.11 adder stage; its result feeds gate pre-activation logic.

---
 rtl/lfp_mac_acc_q6_11_if.sv | 25 ++
 rtl/lfp_mac_acc_q6_11.sv | 135 +++++++++++++
 tb/tb_lfp_mac_acc_q6_11.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lfp_mac_acc_q6_11_if.sv
// Operand-in and result-out valid/ready streams for the Q6.11 MAC engine.
// The master side drives the operands and consumes the result.
interface lfp_mac_acc_q6_11_if #(
  parameter int DATA_W = 18
);
  logic                     clear;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in0_q;
  logic signed [DATA_W-1:0] in1_q;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_q;
  logic                     out_sat;

  modport master (
    output clear, in_valid, in0_q, in1_q, out_ready,
    input  in_ready, out_valid, out_q, out_sat
  );

  modport slave (
    input  clear, in_valid, in0_q, in1_q, out_ready,
    output in_ready, out_valid, out_q, out_sat
  );
endinterface

// File: rtl/lfp_mac_acc_q6_11.sv
// Sequential Q6.11 dot-product engine: accumulates LEN full-precision products,
// then emits one rounded (half toward +inf), saturated Q6.11 result.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_ACC   | accepting operand pairs, one product per cycle
// ST_DRAIN | last product folds into acc; result rounded, saturated, latched
// ST_OUT   | result held on out_q/out_sat until out_ready
module lfp_mac_acc_q6_11 #(
  parameter int DATA_W = 18,
  parameter int FRAC   = 11,
  parameter int LEN    = 16,
  parameter int ACC_W  = 48
) (
  input logic                 clk,
  input logic                 rst_n,
  lfp_mac_acc_q6_11_if.slave  bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 1;
  localparam int CNT_W  = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1) <<< (FRAC - 1);
  localparam logic signed [SUM_W-1:0] MAXV = (SUM_W'(1) <<< (DATA_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] MINV = -MAXV - SUM_W'(1);

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [PROD_W-1:0]  prod;
  logic                      prod_v;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic signed [DATA_W-1:0]  out_q_r;
  logic                      out_sat_r;

  logic signed [PROD_W-1:0]  a_ext;
  logic signed [PROD_W-1:0]  b_ext;
  logic signed [PROD_W-1:0]  prod_nxt;
  logic signed [SUM_W-1:0]   sum_ext;
  logic signed [SUM_W-1:0]   rnd_sum;
  logic signed [SUM_W-1:0]   r;
  logic signed [DATA_W-1:0]  res_q;
  logic                      res_sat;

  assign a_ext    = PROD_W'(bus.in0_q);
  assign b_ext    = PROD_W'(bus.in1_q);
  assign prod_nxt = a_ext * b_ext;

  // Pending product is folded in here, so DRAIN sees the complete sum a cycle early.
  assign sum_ext = SUM_W'(acc) + (prod_v ? SUM_W'(prod) : '0);
  assign rnd_sum = sum_ext + HALF;
  assign r       = rnd_sum >>> FRAC;

  always_comb begin
    res_sat = 1'b0;
    res_q   = r[DATA_W-1:0];
    if (r > MAXV) begin
      res_q   = MAXV[DATA_W-1:0];
      res_sat = 1'b1;
    end else if (r < MINV) begin
      res_q   = MINV[DATA_W-1:0];
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ACC;
      cnt         <= '0;
      acc         <= '0;
      prod        <= '0;
      prod_v      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_q_r     <= '0;
      out_sat_r   <= 1'b0;
    end else if (bus.clear) begin
      state       <= ST_ACC;
      cnt         <= '0;
      acc         <= '0;
      prod_v      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      acc    <= sum_ext[ACC_W-1:0];
      prod_v <= 1'b0;
      case (state)
        ST_ACC: begin
          if (bus.in_valid && in_ready_r) begin
            prod   <= prod_nxt;
            prod_v <= 1'b1;
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              state      <= ST_DRAIN;
              in_ready_r <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          out_q_r     <= res_q;
          out_sat_r   <= res_sat;
          out_valid_r <= 1'b1;
          state       <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            acc         <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= ST_ACC;
          end
        end
        default: begin
          state      <= ST_ACC;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_q     = out_q_r;
  assign bus.out_sat   = out_sat_r;
endmodule

// File: tb/tb_lfp_mac_acc_q6_11.sv
// Directed bench for the Q6.11 MAC engine: a LEN=4 instance for hand-computed
// vectors and a LEN=16 instance for bubble-laden streams against an integer model.
module tb_lfp_mac_acc_q6_11;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  lfp_mac_acc_q6_11_if #(.DATA_W(18)) ifa ();
  lfp_mac_acc_q6_11_if #(.DATA_W(18)) ifb ();

  lfp_mac_acc_q6_11 #(.DATA_W(18), .FRAC(11), .LEN(4), .ACC_W(48)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  lfp_mac_acc_q6_11 #(.DATA_W(18), .FRAC(11), .LEN(16), .ACC_W(48)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int a, input int b);
    int guard;
    guard = 0;
    ifa.in_valid = 1'b1;
    ifa.in0_q    = 18'(a);
    ifa.in1_q    = 18'(b);
    while (!ifa.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("send_a_timeout", 0, 1);
    tick();
    ifa.in_valid = 1'b0;
  endtask

  task automatic recv_a(input string tag, input longint exp_q, input longint exp_sat);
    int guard;
    guard = 0;
    while (!ifa.out_valid && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check({tag, "_timeout"}, 0, 1);
    check({tag, "_q"}, longint'(ifa.out_q), exp_q);
    check({tag, "_sat"}, longint'(ifa.out_sat), exp_sat);
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    check({tag, "_vld_drop"}, longint'(ifa.out_valid), 0);
  endtask

  task automatic run4(input string tag, input int a, input int b,
                      input longint exp_q, input longint exp_sat);
    for (int i = 0; i < 4; i++) send_a(a, b);
    recv_a(tag, exp_q, exp_sat);
  endtask

  // Streams 16 random pairs into dut_b with random idle gaps and checks the model.
  task automatic bubble_run(input string tag, input int range);
    longint sum, r, exp_q, exp_sat;
    int a, b, gap, guard;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      gap = int'($urandom_range(0, 3));
      ifb.in_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      a = int'($urandom_range(0, 2 * range)) - range;
      b = int'($urandom_range(0, 2 * range)) - range;
      if (a > 131071) a = 131071;
      if (b > 131071) b = 131071;
      sum += longint'(a) * longint'(b);
      ifb.in_valid = 1'b1;
      ifb.in0_q    = 18'(a);
      ifb.in1_q    = 18'(b);
      guard = 0;
      while (!ifb.in_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check({tag, "_in_timeout"}, 0, 1);
      tick();
    end
    ifb.in_valid = 1'b0;
    r = (sum + 1024) >>> 11;
    exp_sat = 0;
    exp_q   = r;
    if (r > 131071) begin
      exp_q = 131071;
      exp_sat = 1;
    end else if (r < -131072) begin
      exp_q = -131072;
      exp_sat = 1;
    end
    guard = 0;
    while (!ifb.out_valid && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check({tag, "_out_timeout"}, 0, 1);
    check({tag, "_q"}, longint'(ifb.out_q), exp_q);
    check({tag, "_sat"}, longint'(ifb.out_sat), exp_sat);
    ifb.out_ready = 1'b1;
    tick();
    ifb.out_ready = 1'b0;
  endtask

  initial begin
    int guard;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ifa.clear = 1'b0; ifa.in_valid = 1'b0; ifa.in0_q = '0; ifa.in1_q = '0; ifa.out_ready = 1'b0;
    ifb.clear = 1'b0; ifb.in_valid = 1'b0; ifb.in0_q = '0; ifb.in1_q = '0; ifb.out_ready = 1'b0;

    tick();
    tick();
    check("rst_out_valid", longint'(ifa.out_valid), 0);
    check("rst_out_q", longint'(ifa.out_q), 0);
    check("rst_out_sat", longint'(ifa.out_sat), 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", longint'(ifa.in_ready), 1);

    // Basic with latency: out_valid rises on the second edge after the 4th accept cycle.
    for (int i = 0; i < 4; i++) send_a(2048, 2048);
    check("lat_e1_vld", longint'(ifa.out_valid), 0);
    check("lat_e1_rdy", longint'(ifa.in_ready), 0);
    tick();
    check("lat_e2_vld", longint'(ifa.out_valid), 1);
    recv_a("basic", 8192, 0);

    run4("neg", 4096, -2048, -16384, 0);
    run4("sat_pos", 131071, 131071, 131071, 1);
    run4("sat_neg", -131072, 131071, -131072, 1);

    for (int i = 0; i < 3; i++) send_a(1, 1024);
    send_a(0, 0);
    recv_a("rnd_pos", 2, 0);
    for (int i = 0; i < 3; i++) send_a(-1, 1024);
    send_a(0, 0);
    recv_a("rnd_neg", -1, 0);

    // Backpressure with a waiting input pair.
    for (int i = 0; i < 4; i++) send_a(2048, 2048);
    guard = 0;
    while (!ifa.out_valid && guard < 20) begin
      tick();
      guard++;
    end
    ifa.in_valid = 1'b1;
    ifa.in0_q = 18'(4096);
    ifa.in1_q = 18'(-2048);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", longint'(ifa.in_ready), 0);
      check("bp_out_valid", longint'(ifa.out_valid), 1);
      check("bp_out_q", longint'(ifa.out_q), 8192);
      tick();
    end
    ifa.out_ready = 1'b1;
    tick();
    ifa.out_ready = 1'b0;
    check("bp_hs_vld", longint'(ifa.out_valid), 0);
    check("bp_hs_rdy", longint'(ifa.in_ready), 1);
    tick();
    ifa.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send_a(4096, -2048);
    recv_a("bp_second", -16384, 0);

    // Clear after two accepts, asserted together with a valid pair that must be ignored.
    send_a(1000, 1000);
    send_a(1000, 1000);
    ifa.clear = 1'b1;
    ifa.in_valid = 1'b1;
    ifa.in0_q = 18'(131071);
    ifa.in1_q = 18'(131071);
    tick();
    ifa.clear = 1'b0;
    ifa.in_valid = 1'b0;
    run4("clr_acc", 2048, 2048, 8192, 0);

    // Clear in OUT beats a same-cycle output handshake and drops the result.
    for (int i = 0; i < 4; i++) send_a(131071, 131071);
    tick();
    check("clr_out_pre", longint'(ifa.out_valid), 1);
    ifa.clear = 1'b1;
    ifa.out_ready = 1'b1;
    tick();
    ifa.clear = 1'b0;
    ifa.out_ready = 1'b0;
    check("clr_out_vld", longint'(ifa.out_valid), 0);
    check("clr_out_rdy", longint'(ifa.in_ready), 1);
    run4("clr_out_next", 2048, -2048, -8192, 0);

    // Asynchronous reset while holding a result.
    for (int i = 0; i < 4; i++) send_a(2048, 2048);
    tick();
    check("rst_out_pre", longint'(ifa.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld", longint'(ifa.out_valid), 0);
    check("arst_q", longint'(ifa.out_q), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_rdy", longint'(ifa.in_ready), 1);
    guard = 0;
    for (int i = 0; i < 4; i++) begin
      if (ifa.out_valid) guard++;
      tick();
    end
    check("arst_no_stale", guard, 0);
    run4("arst_next", 4096, -2048, -16384, 0);

    bubble_run("bub_small", 3000);
    bubble_run("bub_mid", 40000);
    bubble_run("bub_full", 131072);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
